// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem read handshake, redirect and decode handoff signals of the fetch stage.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_insn;
  modport master (
    output imem_req, imem_addr, dec_valid, dec_pc, dec_insn,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, dec_ready
  );
  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_pc, dec_insn,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC + single-outstanding imem fetch into a small FIFO feeding decode.
// FETCH_PERF_CNT_EN adds perf_insn_cnt / perf_flush_cnt outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic          clock,
  input logic          reset_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_insn_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;
  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d, addr_q;
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_insn_q [FIFO_DEPTH];
  logic          hs, push, pop;
  // a request is only issued while a FIFO slot is free for its response
  assign bus.imem_req  = state_q == REQ && cnt_q != (AW+1)'(FIFO_DEPTH);
  assign bus.imem_addr = pc_q;
  assign bus.dec_valid = cnt_q != '0;
  assign bus.dec_pc    = bus.dec_valid ? fifo_pc_q[rd_q] : '0;
  assign bus.dec_insn  = bus.dec_valid ? fifo_insn_q[rd_q] : '0;
  assign hs   = bus.imem_req & bus.imem_gnt;
  assign push = state_q == WAIT & bus.imem_rvalid & ~bus.redirect;
  assign pop  = bus.dec_valid & bus.dec_ready & ~bus.redirect;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.redirect ? IDLE : REQ;
      REQ:     state_d = hs ? (bus.redirect ? DROP : WAIT) : REQ;
      WAIT:    state_d = bus.imem_rvalid ? REQ : (bus.redirect ? DROP : WAIT);
      default: state_d = bus.imem_rvalid ? REQ : DROP;
    endcase
    pc_d  = bus.redirect ? bus.redirect_pc & ~32'h3 : hs ? pc_q + 32'd4 : pc_q;
    cnt_d = bus.redirect ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      if (hs) addr_q <= pc_q;
      rd_q <= bus.redirect ? '0 : rd_q + AW'(pop);
      wr_q <= bus.redirect ? '0 : wr_q + AW'(push);
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc_q[wr_q]   <= addr_q;
      fifo_insn_q[wr_q] <= bus.imem_rdata;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] insn_cnt_q, flush_cnt_q;
  assign perf_insn_cnt  = insn_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      insn_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      insn_cnt_q  <= insn_cnt_q + 32'(pop);
      flush_cnt_q <= flush_cnt_q + 32'(bus.redirect && (cnt_q != '0 || hs || state_q == WAIT || state_q == DROP));
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-configurable imem responder.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  logic clk = 0;
  logic rst_n = 1;
  always #5 clk = ~clk;
  fetch_unit_if b();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_insn_cnt, perf_flush_cnt;
`endif
  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clock(clk),
    .reset_n(rst_n),
    .bus(b)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_insn_cnt(perf_insn_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  int passed = 0;
  int total = 0;
  int pops = 0;
  int lat = 1;
  bit gnt_rand = 0;
  bit lat_rand = 0;
  logic [31:0] q[$];
  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ (a << 3);
  endfunction
  // imem responder: one rvalid per grant, lat cycles after it
  initial begin
    bit hs_n;
    logic [31:0] a_n, paddr;
    int cd;
    cd = 0;
    paddr = '0;
    b.imem_gnt = 0;
    b.imem_rvalid = 0;
    b.imem_rdata = 0;
    forever begin
      @(negedge clk);
      hs_n = b.imem_req && b.imem_gnt;
      a_n = b.imem_addr;
      @(posedge clk);
      #1;
      b.imem_rvalid = 0;
      if (!rst_n) cd = 0;
      else begin
        if (hs_n) begin
          paddr = a_n;
          cd = lat_rand ? int'($urandom_range(1, 3)) : lat;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            b.imem_rvalid = 1;
            b.imem_rdata = insn_of(paddr);
          end
        end
      end
      b.imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  // scoreboard: every effective pop must match the next expected PC
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (rst_n && !b.redirect && b.dec_valid && b.dec_ready) begin
      pops++;
      total++;
      if (q.size() == 0) $display("FAIL unexpected_pop: got dec_pc %h, expected none", b.dec_pc);
      else begin
        passed++;
        e = q.pop_front();
        total += 2;
        if (b.dec_pc !== e) $display("FAIL pop_pc: got %h, expected %h", b.dec_pc, e);
        else passed++;
        if (b.dec_insn !== insn_of(e)) $display("FAIL pop_insn: got %h, expected %h", b.dec_insn, insn_of(e));
        else passed++;
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic redir(input logic [31:0] t);
    b.redirect = 1;
    b.redirect_pc = t;
    q.delete();
    @(posedge clk);
    #1;
    b.redirect = 0;
  endtask
  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) q.push_back(start + 32'(4 * i));
  endtask
  task automatic drain(input bit rnd);
    b.dec_ready = 1;
    for (int i = 0; i < 400 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
      b.dec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    b.dec_ready = 0;
    total++;
    if (q.size() != 0) $display("FAIL drain_timeout: got %0d words left, expected 0", q.size());
    else passed++;
  endtask
  task automatic wait_grants(input int n, output bit ok);
    int g = 0;
    for (int i = 0; i < 60 && g < n; i++) begin
      @(negedge clk);
      if (b.imem_req && b.imem_gnt) g++;
    end
    ok = g == n;
  endtask
  task automatic test_reset;
    #1 rst_n = 0;
    #2;
    total += 5;
    if (b.imem_req !== 1'b0) $display("FAIL rst_req: got %b, expected 0", b.imem_req); else passed++;
    if (b.imem_addr !== RESET_PC) $display("FAIL rst_addr: got %h, expected %h", b.imem_addr, RESET_PC); else passed++;
    if (b.dec_valid !== 1'b0) $display("FAIL rst_valid: got %b, expected 0", b.dec_valid); else passed++;
    if (b.dec_pc !== 32'h0) $display("FAIL rst_pc: got %h, expected 0", b.dec_pc); else passed++;
    if (b.dec_insn !== 32'h0) $display("FAIL rst_insn: got %h, expected 0", b.dec_insn); else passed++;
`ifdef FETCH_PERF_CNT_EN
    total += 2;
    if (perf_insn_cnt !== 32'h0) $display("FAIL rst_perf_insn: got %0d, expected 0", perf_insn_cnt); else passed++;
    if (perf_flush_cnt !== 32'h0) $display("FAIL rst_perf_flush: got %0d, expected 0", perf_flush_cnt); else passed++;
`endif
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    total++;
    if (b.imem_req !== 1'b0) $display("FAIL idle_req: got %b, expected 0", b.imem_req); else passed++;
    @(negedge clk);
    total += 2;
    if (b.imem_req !== 1'b1) $display("FAIL first_req: got %b, expected 1", b.imem_req); else passed++;
    if (b.imem_addr !== RESET_PC) $display("FAIL first_addr: got %h, expected %h", b.imem_addr, RESET_PC); else passed++;
  endtask
  task automatic test_stream;
    push_seq(RESET_PC, 6);
    @(posedge clk);
    #1;
    drain(0);
  endtask
  task automatic test_backpressure;
    int g = 0;
    idle(10);
    redir(32'h0040_0200);
    repeat (20) begin
      @(negedge clk);
      if (b.imem_req && b.imem_gnt) g++;
    end
    total += 3;
    if (g != 2) $display("FAIL bp_grants: got %0d, expected 2", g); else passed++;
    if (b.imem_req !== 1'b0) $display("FAIL bp_req_off: got %b, expected 0", b.imem_req); else passed++;
    if (b.dec_pc !== 32'h0040_0200) $display("FAIL bp_head: got %h, expected 00400200", b.dec_pc); else passed++;
    repeat (3) @(negedge clk);
    total += 2;
    if (b.dec_pc !== 32'h0040_0200) $display("FAIL bp_head_stable: got %h, expected 00400200", b.dec_pc); else passed++;
    if (b.dec_insn !== insn_of(32'h0040_0200)) $display("FAIL bp_insn_stable: got %h, expected %h", b.dec_insn, insn_of(32'h0040_0200)); else passed++;
    @(posedge clk);
    #1;
    push_seq(32'h0040_0200, 6);
    drain(0);
  endtask
  task automatic test_redirect_wait;
    bit ok;
    idle(10);
    lat = 3;
    redir(32'h0040_0600);
    wait_grants(2, ok);
    @(posedge clk);
    #1;
    total += 2;
    if (!ok) $display("FAIL rw_grants: got timeout, expected 2 grants"); else passed++;
    if (b.dec_valid !== 1'b1) $display("FAIL rw_prefill: got %b, expected 1", b.dec_valid); else passed++;
    redir(32'h0040_0103);
    total += 3;
    if (b.dec_valid !== 1'b0) $display("FAIL rw_flush: got %b, expected 0", b.dec_valid); else passed++;
    if (b.dec_insn !== 32'h0) $display("FAIL rw_nop: got %h, expected 0", b.dec_insn); else passed++;
    if (b.imem_addr !== 32'h0040_0100) $display("FAIL rw_align: got %h, expected 00400100", b.imem_addr); else passed++;
    push_seq(32'h0040_0100, 3);
    drain(0);
    lat = 1;
  endtask
  task automatic test_redirect_rvalid;
    bit ok;
    idle(10);
    redir(32'h0040_0280);
    wait_grants(1, ok);
    @(posedge clk);
    #1;
    redir(32'h0040_0300);
    total += 4;
    if (!ok) $display("FAIL rv_grant: got timeout, expected 1 grant"); else passed++;
    if (b.dec_valid !== 1'b0) $display("FAIL rv_no_push: got %b, expected 0", b.dec_valid); else passed++;
    if (b.imem_req !== 1'b1) $display("FAIL rv_req: got %b, expected 1", b.imem_req); else passed++;
    if (b.imem_addr !== 32'h0040_0300) $display("FAIL rv_addr: got %h, expected 00400300", b.imem_addr); else passed++;
    push_seq(32'h0040_0300, 3);
    drain(0);
  endtask
  task automatic test_redirect_gnt;
    idle(10);
    redir(32'h0040_0400);
    total += 2;
    if (b.imem_req !== 1'b1) $display("FAIL rg_req: got %b, expected 1", b.imem_req); else passed++;
    if (b.imem_addr !== 32'h0040_0400) $display("FAIL rg_addr: got %h, expected 00400400", b.imem_addr); else passed++;
    redir(32'h0040_0500);
    total++;
    if (b.imem_req !== 1'b0) $display("FAIL rg_drop_req: got %b, expected 0", b.imem_req); else passed++;
    push_seq(32'h0040_0500, 3);
    drain(0);
  endtask
  task automatic test_wrap;
    idle(10);
    redir(32'hFFFF_FFF8);
    push_seq(32'hFFFF_FFF8, 4);
    drain(0);
  endtask
  task automatic test_random;
    idle(10);
    gnt_rand = 1;
    lat_rand = 1;
    redir(32'h0040_1000);
    push_seq(32'h0040_1000, 12);
    drain(1);
    gnt_rand = 0;
    lat_rand = 0;
  endtask
  task automatic test_reset_mid;
    bit ok;
    idle(10);
    lat = 3;
    redir(32'h0040_2000);
    wait_grants(2, ok);
    @(posedge clk);
    #1;
    total++;
    if (!ok) $display("FAIL rm_grants: got timeout, expected 2 grants"); else passed++;
    rst_n = 0;
    q.delete();
    #1;
    total += 5;
    if (b.imem_req !== 1'b0) $display("FAIL rm_req: got %b, expected 0", b.imem_req); else passed++;
    if (b.imem_addr !== RESET_PC) $display("FAIL rm_addr: got %h, expected %h", b.imem_addr, RESET_PC); else passed++;
    if (b.dec_valid !== 1'b0) $display("FAIL rm_valid: got %b, expected 0", b.dec_valid); else passed++;
    if (b.dec_pc !== 32'h0) $display("FAIL rm_pc: got %h, expected 0", b.dec_pc); else passed++;
    if (b.dec_insn !== 32'h0) $display("FAIL rm_insn: got %h, expected 0", b.dec_insn); else passed++;
    pops = 0;
`ifdef FETCH_PERF_CNT_EN
    total += 2;
    if (perf_insn_cnt !== 32'h0) $display("FAIL rm_perf_insn: got %0d, expected 0", perf_insn_cnt); else passed++;
    if (perf_flush_cnt !== 32'h0) $display("FAIL rm_perf_flush: got %0d, expected 0", perf_flush_cnt); else passed++;
`endif
    repeat (3) @(posedge clk);
    #1;
    lat = 1;
    rst_n = 1;
    push_seq(RESET_PC, 3);
    drain(0);
`ifdef FETCH_PERF_CNT_EN
    idle(6);
    redir(RESET_PC);
    total += 2;
    if (perf_insn_cnt !== 32'(pops)) $display("FAIL perf_insn: got %0d, expected %0d", perf_insn_cnt, pops); else passed++;
    if (perf_flush_cnt !== 32'd1) $display("FAIL perf_flush: got %0d, expected 1", perf_flush_cnt); else passed++;
`endif
  endtask
  initial begin
    b.redirect = 0;
    b.redirect_pc = 0;
    b.dec_ready = 0;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_wait;
    test_redirect_rvalid;
    test_redirect_gnt;
    test_wrap;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
